// File: rtl/uart_unlock_ctrl.sv
// uart_unlock_ctrl: matches received UART bytes against a fixed key,
// pulses the open actuator for a hold time, and locks out after too many
// consecutive failed attempts.
// Optional status byte channel: define UNLOCK_STATUS_EN.
module uart_unlock_ctrl #(
  parameter int          KEY_LEN        = 2,
  parameter logic [63:0] KEY            = 64'h0000_0000_0000_3F55,
  parameter int          HOLD_CYCLES    = 12000000,
  parameter int          GAP_CYCLES     = 24000,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 120000000
) (
  input  logic       clk_12,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       rx_frame_err,
  output logic       open,
  output logic       locked,
  output logic [3:0] fail_count
`ifdef UNLOCK_STATUS_EN
  ,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready
`endif
);

  localparam int IW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MATCH, S_OPEN, S_LOCK} state_t;

  state_t        r_state, w_state_nx;
  logic [IW-1:0] r_idx, w_idx_nx;
  logic [GW-1:0] r_gap, w_gap_nx;
  logic [HW-1:0] r_hold, w_hold_nx;
  logic [LW-1:0] r_lock, w_lock_nx;
  logic          r_open, w_open_nx;
  logic          r_locked, w_locked_nx;
  logic [3:0]    r_fail, w_fail_nx;
  logic [3:0]    w_fail_inc;
  logic [7:0]    w_key_byte;
  logic          w_bad;
  logic          w_ev_open, w_ev_fail, w_ev_lock;

  // key byte expected at the current match position (idx is 0 in IDLE)
  assign w_key_byte = KEY[{r_idx, 3'b000} +: 8];
  assign w_fail_inc = (r_fail == 4'(MAX_FAILS)) ? r_fail : r_fail + 4'd1;

  // next-state, timers and output registers' next values
  always_comb begin
    w_state_nx  = r_state;
    w_idx_nx    = r_idx;
    w_gap_nx    = r_gap;
    w_hold_nx   = r_hold;
    w_lock_nx   = r_lock;
    w_open_nx   = r_open;
    w_locked_nx = r_locked;
    w_fail_nx   = r_fail;
    w_bad       = 1'b0;
    w_ev_open   = 1'b0;
    w_ev_fail   = 1'b0;
    w_ev_lock   = 1'b0;
    case (r_state)
      S_IDLE, S_MATCH: begin
        // a framing error wins over a simultaneous byte strobe
        if (rx_frame_err) begin
          w_bad = 1'b1;
        end else if (rx_valid) begin
          if (rx_data == w_key_byte) begin
            w_gap_nx = '0;
            if (r_idx == IW'(KEY_LEN - 1)) begin
              w_state_nx = S_OPEN;
              w_idx_nx   = '0;
              w_open_nx  = 1'b1;
              w_hold_nx  = '0;
              w_fail_nx  = 4'd0;
              w_ev_open  = 1'b1;
            end else begin
              w_state_nx = S_MATCH;
              w_idx_nx   = r_idx + 1'b1;
            end
          end else begin
            w_bad = 1'b1;
          end
        end else if (r_state == S_MATCH) begin
          // abandon the attempt once GAP_CYCLES idle cycles have elapsed
          if (r_gap == GW'(GAP_CYCLES - 1)) w_bad = 1'b1;
          else                              w_gap_nx = r_gap + 1'b1;
        end
        if (w_bad) begin
          w_fail_nx = w_fail_inc;
          w_idx_nx  = '0;
          w_gap_nx  = '0;
          if (w_fail_inc == 4'(MAX_FAILS)) begin
            w_state_nx  = S_LOCK;
            w_locked_nx = 1'b1;
            w_lock_nx   = '0;
            w_ev_lock   = 1'b1;
          end else begin
            w_state_nx = S_IDLE;
            w_ev_fail  = 1'b1;
          end
        end
      end
      S_OPEN: begin
        // bytes are ignored; the hold is a fixed length
        if (r_hold == HW'(HOLD_CYCLES - 1)) begin
          w_state_nx = S_IDLE;
          w_open_nx  = 1'b0;
          w_hold_nx  = '0;
        end else begin
          w_hold_nx = r_hold + 1'b1;
        end
      end
      S_LOCK: begin
        if (r_lock == LW'(LOCKOUT_CYCLES - 1)) begin
          w_state_nx  = S_IDLE;
          w_locked_nx = 1'b0;
          w_lock_nx   = '0;
          w_fail_nx   = 4'd0;
        end else begin
          w_lock_nx = r_lock + 1'b1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // state, timer and output registers
  always_ff @(posedge clk_12) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_gap    <= '0;
      r_hold   <= '0;
      r_lock   <= '0;
      r_open   <= 1'b0;
      r_locked <= 1'b0;
      r_fail   <= 4'd0;
    end else begin
      r_state  <= w_state_nx;
      r_idx    <= w_idx_nx;
      r_gap    <= w_gap_nx;
      r_hold   <= w_hold_nx;
      r_lock   <= w_lock_nx;
      r_open   <= w_open_nx;
      r_locked <= w_locked_nx;
      r_fail   <= w_fail_nx;
    end
  end

  assign open       = r_open;
  assign locked     = r_locked;
  assign fail_count = r_fail;

`ifdef UNLOCK_STATUS_EN
  logic       r_tx_valid;
  logic [7:0] r_tx_data;

  // one-entry status buffer; a new event overwrites a pending byte
  always_ff @(posedge clk_12) begin
    if (!rst_n) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else if (w_ev_open) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= 8'h4F;
    end else if (w_ev_lock) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= 8'h4C;
    end else if (w_ev_fail) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= 8'h46;
    end else if (r_tx_valid && tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
`endif

endmodule

// File: tb/tb_uart_unlock_ctrl.sv
// Directed bench for uart_unlock_ctrl with shortened timing parameters.
module tb_uart_unlock_ctrl;

  logic       clk_12 = 1'b0;
  logic       rst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       open;
  logic       locked;
  logic [3:0] fail_count;
`ifdef UNLOCK_STATUS_EN
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
`endif

  int checks   = 0;
  int failures = 0;

  uart_unlock_ctrl #(
    .KEY_LEN       (2),
    .KEY           (64'h3F55),
    .HOLD_CYCLES   (50),
    .GAP_CYCLES    (200),
    .MAX_FAILS     (3),
    .LOCKOUT_CYCLES(100)
  ) dut (
    .clk_12      (clk_12),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_frame_err(rx_frame_err),
    .open        (open),
    .locked      (locked),
    .fail_count  (fail_count)
`ifdef UNLOCK_STATUS_EN
    ,
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready)
`endif
  );

  always #5 clk_12 = ~clk_12;

  task automatic tick();
    @(posedge clk_12);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_open_low(input string tag);
    int n;
    n = 0;
    while (open && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(open), 32'd0);
  endtask

  initial begin
    int n;
    logic saw_open;
    rst_n        = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    rx_frame_err = 1'b0;
`ifdef UNLOCK_STATUS_EN
    tx_ready     = 1'b0;
`endif
    idle(3);
    chk("rst_open", 32'(open), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_fail", 32'(fail_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // correct key, strobes 10 cycles apart; a stray byte mid-hold is ignored
    send(8'h55);
    idle(9);
    chk("t1_pre_open", 32'(open), 32'd0);
    send(8'h3F);
    chk("t1_open", 32'(open), 32'd1);
    chk("t1_fail", 32'(fail_count), 32'd0);
    n = 0;
    while (open && n < 200) begin
      n++;
      if (n == 5) begin
        rx_valid = 1'b1;
        rx_data  = 8'h00;
      end
      tick();
      rx_valid = 1'b0;
    end
    chk("t1_hold_len", 32'(n), 32'd50);
    chk("t1_fail_after", 32'(fail_count), 32'd0);

    // wrong second byte, then a good attempt clears the count
    send(8'h55);
    send(8'h12);
    chk("t2_open", 32'(open), 32'd0);
    chk("t2_fail", 32'(fail_count), 32'd1);
    send(8'h55);
    send(8'h3F);
    chk("t2_reopen", 32'(open), 32'd1);
    chk("t2_fail_clr", 32'(fail_count), 32'd0);
    wait_open_low("t2_close");

    // three failures trigger lockout; key ignored while locked
    send(8'h00);
    chk("t3_fail1", 32'(fail_count), 32'd1);
    chk("t3_nolock1", 32'(locked), 32'd0);
    send(8'h00);
    chk("t3_fail2", 32'(fail_count), 32'd2);
    send(8'h00);
    chk("t3_fail3", 32'(fail_count), 32'd3);
    chk("t3_locked", 32'(locked), 32'd1);
    n = 0;
    saw_open = 1'b0;
    while (locked && n < 300) begin
      n++;
      if (n == 10) begin rx_valid = 1'b1; rx_data = 8'h55; end
      if (n == 11) begin rx_valid = 1'b1; rx_data = 8'h3F; end
      tick();
      rx_valid = 1'b0;
      if (open) saw_open = 1'b1;
    end
    chk("t3_lock_len", 32'(n), 32'd100);
    chk("t3_no_open", 32'(saw_open), 32'd0);
    chk("t3_fail_clr", 32'(fail_count), 32'd0);

    // gap boundary: 199 idle cycles still matches
    send(8'h55);
    idle(199);
    send(8'h3F);
    chk("t4_gap199_open", 32'(open), 32'd1);
    wait_open_low("t4_close");

    // gap expiry: attempt abandoned, late byte is a wrong byte in IDLE
    send(8'h55);
    idle(201);
    chk("t4_gap_fail", 32'(fail_count), 32'd1);
    send(8'h3F);
    chk("t4_late_open", 32'(open), 32'd0);
    chk("t4_late_fail", 32'(fail_count), 32'd2);
    send(8'h55);
    send(8'h3F);
    chk("t4_reopen", 32'(open), 32'd1);
    chk("t4_fail_clr", 32'(fail_count), 32'd0);
    wait_open_low("t4_close2");

    // frame error with a key byte: one fail, byte not taken as key start
    rx_valid     = 1'b1;
    rx_frame_err = 1'b1;
    rx_data      = 8'h55;
    tick();
    rx_valid     = 1'b0;
    rx_frame_err = 1'b0;
    chk("t5_ferr_fail", 32'(fail_count), 32'd1);
    send(8'h3F);
    chk("t5_no_start", 32'(open), 32'd0);
    chk("t5_fail2", 32'(fail_count), 32'd2);

    // reset mid-OPEN
    send(8'h55);
    send(8'h3F);
    idle(5);
    chk("t6_open_mid", 32'(open), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_open", 32'(open), 32'd0);
    rst_n = 1'b1;
    tick();

    // reset mid-LOCKOUT
    send(8'h00);
    send(8'h00);
    send(8'h00);
    idle(5);
    chk("t6_lock_mid", 32'(locked), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("t6_rst_locked", 32'(locked), 32'd0);
    chk("t6_rst_fail", 32'(fail_count), 32'd0);
    rst_n = 1'b1;
    tick();

`ifdef UNLOCK_STATUS_EN
    chk("tx_rst_valid", 32'(tx_valid), 32'd0);
    send(8'h55);
    send(8'h3F);
    chk("tx_valid", 32'(tx_valid), 32'd1);
    chk("tx_data", 32'(tx_data), 32'h4F);
    idle(3);
    chk("tx_hold_valid", 32'(tx_valid), 32'd1);
    chk("tx_hold_data", 32'(tx_data), 32'h4F);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("tx_accept", 32'(tx_valid), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
